accel_issue_ctrl: RTL and testbench

//  Multi-cycle issue/writeback sequencer for custom-0 accelerator instructions (relu/matmul/dotprod and

---
 rtl/accel_issue_ctrl_pkg.sv | 12 +
 rtl/accel_issue_ctrl_timeout_ctr.sv | 19 +
 rtl/accel_issue_ctrl.sv | 118 +++++++++++
 tb/tb_accel_issue_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/accel_issue_ctrl_pkg.sv
// accel_pkg: shared opcode, op-code and FSM state constants for the custom-0 issue controller.
package accel_pkg;
    localparam logic [6:0] CUSTOM0     = 7'b0001011;
    localparam logic [2:0] OP_RELU     = 3'd0;
    localparam logic [2:0] OP_MATMUL   = 3'd1;
    localparam logic [2:0] OP_DOTPROD  = 3'd2;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_WB    = 2'd3;
endpackage

// File: rtl/accel_issue_ctrl_timeout_ctr.sv
// accel_timeout_ctr: clearable up-counter flagging when it reaches its terminal count.
module accel_timeout_ctr #(
    parameter int W    = 8,
    parameter int TERM = 254
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    assign tc_o  = cnt_q == W'(TERM);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/accel_issue_ctrl.sv
// accel_issue_ctrl: stalls the pipeline around a custom-0 instruction, launches one accelerator
// unit, waits for its done pulse (bounded by a timeout) and returns a one-cycle rd writeback.
module accel_issue_ctrl
    import accel_pkg::*;
#(
    parameter int         XLEN      = 32,
    parameter int         NUM_OPS   = 4,
    parameter int         MAX_LEN   = 16,
    parameter int         TIMEOUT   = 255,
    parameter logic [6:0] CUSTOM_OP = CUSTOM0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         instr_valid_i,
    input  logic [6:0]                   opcode_i,
    input  logic [2:0]                   funct3_i,
    input  logic [6:0]                   funct7_i,
    input  logic [4:0]                   rd_i,
    input  logic [XLEN-1:0]              rs1_val_i,
    input  logic [XLEN-1:0]              rs2_val_i,
    input  logic                         flush_i,
    input  logic [NUM_OPS-1:0]           acc_done_i,
    input  logic [XLEN*NUM_OPS-1:0]      acc_result_i,
    output logic                         stall_o,
    output logic [NUM_OPS-1:0]           acc_start_o,
    output logic                         acc_abort_o,
    output logic [$clog2(MAX_LEN+1)-1:0] acc_len_o,
    output logic [XLEN-1:0]              acc_a_o,
    output logic [XLEN-1:0]              acc_b_o,
    output logic                         wb_valid_o,
    output logic [4:0]                   wb_rd_o,
    output logic [XLEN-1:0]              wb_data_o,
    output logic                         illegal_o,
    output logic                         timeout_o
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   a_q, b_q, data_q, res_sel;
    logic [LW-1:0]     len_q, len_d;
    logic [6:0]        len_raw;
    logic              hit, legal, accept, done_sel, tc, busy, in_wait, unused_f7;

    // flush on the accept cycle suppresses both the accept and the illegal flag
    assign hit       = state_q == ST_IDLE && instr_valid_i && opcode_i == CUSTOM_OP && !flush_i;
    assign legal     = {1'b0, funct3_i} < 4'(NUM_OPS);
    assign accept    = hit && legal;
    assign illegal_o = hit && !legal;
    assign unused_f7 = ^funct7_i[6:5];

    assign len_raw = {2'b0, funct7_i[4:0]} + 7'd1;
    assign len_d   = (len_raw > 7'(MAX_LEN)) ? LW'(MAX_LEN) : LW'(len_raw);

    always_comb begin
        done_sel = 1'b0;
        res_sel  = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (op_q == 3'(i)) begin
                done_sel = acc_done_i[i];
                res_sel  = acc_result_i[i*XLEN +: XLEN];
            end
        end
    end

    accel_timeout_ctr #(.W(CW), .TERM(TIMEOUT - 1)) u_ctr (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (!in_wait),
        .en_i  (in_wait),
        .tc_o  (tc)
    );

    assign in_wait = state_q == ST_WAIT;
    assign busy    = state_q == ST_START || in_wait;

    // flush beats done, and done beats a coincident timeout
    assign state_d = (state_q == ST_IDLE)  ? (accept ? ST_START : ST_IDLE) :
                     (state_q == ST_START) ? (flush_i ? ST_IDLE : ST_WAIT) :
                     in_wait               ? (flush_i ? ST_IDLE : done_sel ? ST_WB : tc ? ST_IDLE : ST_WAIT) :
                     ST_IDLE;

    assign timeout_o   = in_wait && tc && !done_sel && !flush_i;
    assign acc_abort_o = (busy && flush_i) || timeout_o;
    // the front end is released in the same cycle WAIT resolves
    assign stall_o     = accept || state_q == ST_START || (in_wait && !flush_i && !done_sel && !tc);
    assign acc_start_o = (state_q == ST_START) ? NUM_OPS'(1) << op_q : '0;
    assign acc_len_o   = busy ? len_q : '0;
    assign acc_a_o     = busy ? a_q : '0;
    assign acc_b_o     = busy ? b_q : '0;
    assign wb_valid_o  = state_q == ST_WB && rd_q != 5'd0;
    assign wb_rd_o     = (state_q == ST_WB) ? rd_q : '0;
    assign wb_data_o   = (state_q == ST_WB) ? data_q : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            len_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= funct3_i;
                rd_q  <= rd_i;
                a_q   <= rs1_val_i;
                b_q   <= rs2_val_i;
                len_q <= len_d;
            end
            if (in_wait && done_sel && !flush_i) data_q <= res_sel;
        end
    end
endmodule

// File: tb/tb_accel_issue_ctrl.sv
// tb_accel_issue_ctrl: directed vectors with hand-computed expectations for accel_issue_ctrl.
module tb_accel_issue_ctrl;
    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         instr_valid_i;
    logic [6:0]   opcode_i;
    logic [2:0]   funct3_i;
    logic [6:0]   funct7_i;
    logic [4:0]   rd_i;
    logic [31:0]  rs1_val_i, rs2_val_i;
    logic         flush_i;
    logic [3:0]   acc_done_i;
    logic [127:0] acc_result_i;
    logic         stall_o, acc_abort_o, wb_valid_o, illegal_o, timeout_o;
    logic [3:0]   acc_start_o;
    logic [4:0]   acc_len_o, wb_rd_o;
    logic [31:0]  acc_a_o, acc_b_o, wb_data_o;
    int           n_chk = 0;
    int           n_pass = 0;

    always #5 clk_i = ~clk_i;

    accel_issue_ctrl #(.TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .instr_valid_i(instr_valid_i), .opcode_i(opcode_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .rd_i(rd_i), .rs1_val_i(rs1_val_i),
        .rs2_val_i(rs2_val_i), .flush_i(flush_i), .acc_done_i(acc_done_i), .acc_result_i(acc_result_i),
        .stall_o(stall_o), .acc_start_o(acc_start_o), .acc_abort_o(acc_abort_o), .acc_len_o(acc_len_o),
        .acc_a_o(acc_a_o), .acc_b_o(acc_b_o), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .illegal_o(illegal_o), .timeout_o(timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // advance to the next cycle's drive point with all pulse inputs cleared
    task automatic cyc();
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        flush_i       = 1'b0;
        acc_done_i    = '0;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        instr_valid_i = 1'b1;
        opcode_i      = op;
        funct3_i      = f3;
        funct7_i      = f7;
        rd_i          = rd;
        rs1_val_i     = a;
        rs2_val_i     = b;
    endtask

    initial begin
        rst_ni = 1'b0; instr_valid_i = 0; opcode_i = 0; funct3_i = 0; funct7_i = 0; rd_i = 0;
        rs1_val_i = 0; rs2_val_i = 0; flush_i = 0; acc_done_i = 0; acc_result_i = '0;
        #12;
        check("rst_stall", 32'(stall_o), 0);
        check("rst_start", 32'(acc_start_o), 0);
        check("rst_wb", 32'(wb_valid_o), 0);
        check("rst_len", 32'(acc_len_o), 0);
        cyc(); rst_ni = 1'b1;

        // basic matmul: accept c0, start c1, done c4, wb c5
        cyc(); issue(7'b0001011, 3'd1, 7'd3, 5'd5, 32'hA5, 32'h5A); #1;
        check("acc_stall_c0", 32'(stall_o), 1);
        check("acc_start_c0", 32'(acc_start_o), 0);
        cyc(); #1;
        check("start_c1", 32'(acc_start_o), 32'b0010);
        check("len_c1", 32'(acc_len_o), 4);
        check("a_c1", acc_a_o, 32'hA5);
        check("b_c1", acc_b_o, 32'h5A);
        check("stall_c1", 32'(stall_o), 1);
        cyc(); #1;
        check("start_c2", 32'(acc_start_o), 0);
        check("stall_c2", 32'(stall_o), 1);
        cyc(); #1;
        check("stall_c3", 32'(stall_o), 1);
        check("len_c3", 32'(acc_len_o), 4);
        cyc(); acc_done_i = 4'b0010; acc_result_i[63:32] = 32'h1234; #1;
        check("wb_c4", 32'(wb_valid_o), 0);
        check("stall_c4", 32'(stall_o), 0);
        cyc(); issue(7'b0001011, 3'd0, 7'd0, 5'd6, 0, 0); #1;
        check("wb_valid_c5", 32'(wb_valid_o), 1);
        check("wb_rd_c5", 32'(wb_rd_o), 5);
        check("wb_data_c5", wb_data_o, 32'h1234);
        check("stall_c5", 32'(stall_o), 0);
        cyc(); #1;
        check("no_accept_in_wb", 32'(acc_start_o), 0);
        check("wb_c6", 32'(wb_valid_o), 0);

        // illegal funct3 and a foreign opcode
        cyc(); issue(7'b0001011, 3'd5, 7'd0, 5'd1, 0, 0); #1;
        check("illegal", 32'(illegal_o), 1);
        check("illegal_stall", 32'(stall_o), 0);
        cyc(); #1;
        check("illegal_pulse", 32'(illegal_o), 0);
        check("illegal_nostart", 32'(acc_start_o), 0);
        cyc(); issue(7'b0110011, 3'd1, 7'd0, 5'd1, 0, 0); #1;
        check("foreign_stall", 32'(stall_o), 0);
        check("foreign_illegal", 32'(illegal_o), 0);
        cyc(); #1;
        check("foreign_nostart", 32'(acc_start_o), 0);

        // flush on accept cycle, legal and illegal
        cyc(); issue(7'b0001011, 3'd5, 7'd0, 5'd1, 0, 0); flush_i = 1'b1; #1;
        check("flush_illegal", 32'(illegal_o), 0);
        cyc(); issue(7'b0001011, 3'd1, 7'd0, 5'd1, 0, 0); flush_i = 1'b1; #1;
        check("flush_accept_stall", 32'(stall_o), 0);
        cyc(); #1;
        check("flush_accept_nostart", 32'(acc_start_o), 0);

        // len clamp then timeout at c9; done from another unit ignored
        cyc(); issue(7'b0001011, 3'd0, 7'd31, 5'd7, 0, 0); #1;
        cyc(); #1;
        check("clamp_len", 32'(acc_len_o), 16);
        check("clamp_start", 32'(acc_start_o), 32'b0001);
        for (int k = 2; k <= 9; k++) begin
            cyc();
            if (k == 5) acc_done_i = 4'b0010;
            #1;
            if (k == 8) begin
                check("to_c8_timeout", 32'(timeout_o), 0);
                check("to_c8_stall", 32'(stall_o), 1);
            end
        end
        check("to_timeout", 32'(timeout_o), 1);
        check("to_abort", 32'(acc_abort_o), 1);
        check("to_stall", 32'(stall_o), 0);
        cyc(); #1;
        check("to_after_wb", 32'(wb_valid_o), 0);
        check("to_after_abort", 32'(acc_abort_o), 0);
        check("to_after_timeout", 32'(timeout_o), 0);

        // flush in WAIT, later done ignored
        cyc(); issue(7'b0001011, 3'd2, 7'd1, 5'd3, 0, 0); #1;
        cyc(); #1;
        check("fl_start", 32'(acc_start_o), 32'b0100);
        cyc(); flush_i = 1'b1; #1;
        check("fl_abort", 32'(acc_abort_o), 1);
        check("fl_timeout", 32'(timeout_o), 0);
        cyc(); acc_done_i = 4'b0100; acc_result_i[95:64] = 32'hDEAD; #1;
        check("fl_abort_pulse", 32'(acc_abort_o), 0);
        check("fl_idle_stall", 32'(stall_o), 0);
        cyc(); #1;
        check("fl_no_wb", 32'(wb_valid_o), 0);

        // rd=0: earliest done, no writeback, then back-to-back accept right after WB
        cyc(); issue(7'b0001011, 3'd3, 7'd0, 5'd0, 0, 0); #1;
        cyc(); #1;
        cyc(); acc_done_i = 4'b1000; acc_result_i[127:96] = 32'h55; #1;
        cyc(); #1;
        check("rd0_wb", 32'(wb_valid_o), 0);
        cyc(); issue(7'b0001011, 3'd0, 7'd0, 5'd9, 0, 0); #1;
        check("b2b_stall", 32'(stall_o), 1);
        cyc(); #1;
        check("b2b_start", 32'(acc_start_o), 32'b0001);
        // done coincides with terminal count: done wins
        for (int k = 6; k <= 13; k++) begin
            cyc();
            if (k == 13) begin acc_done_i = 4'b0001; acc_result_i[31:0] = 32'h77; end
            #1;
        end
        check("dt_timeout", 32'(timeout_o), 0);
        check("dt_abort", 32'(acc_abort_o), 0);
        cyc(); flush_i = 1'b1; #1;
        check("dt_wb", 32'(wb_valid_o), 1);
        check("dt_data", wb_data_o, 32'h77);
        check("dt_rd", 32'(wb_rd_o), 9);
        check("wb_flush_abort", 32'(acc_abort_o), 0);

        // asynchronous reset mid-WAIT
        cyc(); issue(7'b0001011, 3'd1, 7'd2, 5'd4, 32'h11, 32'h22); #1;
        cyc(); #1;
        cyc(); #1;
        check("pre_rst_stall", 32'(stall_o), 1);
        #2 rst_ni = 1'b0; #1;
        check("arst_stall", 32'(stall_o), 0);
        check("arst_len", 32'(acc_len_o), 0);
        check("arst_a", acc_a_o, 0);
        check("arst_abort", 32'(acc_abort_o), 0);
        cyc(); rst_ni = 1'b1;
        cyc(); acc_done_i = 4'b0010; #1;
        cyc(); #1;
        check("arst_no_wb", 32'(wb_valid_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
